// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional icache is enabled by defining ICACHE_EN.
package inst_fetch_pkg;

  localparam int unsigned STALL_W = 6;

  typedef logic [31:0]        inst_addr_t;
  typedef logic [31:0]        inst_t;
  typedef logic [STALL_W-1:0] stall_t;

  localparam inst_t ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'b00,
    IF_BUSY = 2'b01,
    IF_DROP = 2'b10
  } if_state_e;

  function automatic inst_addr_t next_pc(input inst_addr_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped, one-word-per-line instruction cache used by inst_fetch
// when ICACHE_EN is defined. Lines are invalidated only by reset.
module inst_fetch_icache
  import inst_fetch_pkg::*;
#(
  parameter int unsigned LINES = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  inst_addr_t lookup_addr_i,
  output logic       hit_o,
  output inst_t      data_o,
  input  logic       fill_we_i,
  input  inst_addr_t fill_addr_i,
  input  inst_t      fill_data_i
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  inst_t            data_q [LINES];

  logic [IDX_W-1:0] lookup_idx, fill_idx;
  logic [TAG_W-1:0] lookup_tag, fill_tag;
  logic             addr_unused;

  assign lookup_idx  = lookup_addr_i[IDX_W+1:2];
  assign lookup_tag  = lookup_addr_i[31:IDX_W+2];
  assign fill_idx    = fill_addr_i[IDX_W+1:2];
  assign fill_tag    = fill_addr_i[31:IDX_W+2];
  assign addr_unused = ^{lookup_addr_i[1:0], fill_addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (fill_we_i) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset: a line is only read once its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data_i;
    end
  end

  assign hit_o  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign data_o = data_q[lookup_idx];

endmodule

// File: rtl/inst_fetch.sv
// IF stage: owns the PC, fetches through the memory-controller port and holds one
// instruction for if_id. Define ICACHE_EN to add the direct-mapped icache.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rdy_i,
  input  stall_t     stall_stat_i,
  input  logic       ex_is_branch_i,
  input  inst_addr_t ex_branch_pc_i,
  input  inst_addr_t id_pc_i,
  input  logic       mem_done_i,
  input  inst_t      mem_inst_i,
  output logic       if_mem_req_o,
  output inst_addr_t if_mem_addr_o,
  output inst_addr_t if_pc_o,
  output inst_t      if_inst_o,
  output logic       if_stall_req_o
);

  if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_lines_check
    $error("ICACHE_LINES must be a power of 2");
  end

  if_state_e  state_q, state_d;
  inst_addr_t pc_q, pc_d;
  inst_addr_t mem_addr_q, mem_addr_d;
  inst_t      inst_buf_q, inst_buf_d;
  logic       inst_valid_q, inst_valid_d;
  logic       mem_req_q, mem_req_d;

  logic  redirect, consume, fill_we, cache_hit, stall_unused;
  inst_t cache_data;

  // Must match the if_id flush condition exactly, or IF and ID disagree on the stream.
  assign redirect     = ex_is_branch_i && (ex_branch_pc_i != id_pc_i);
  assign consume      = inst_valid_q && !stall_stat_i[0];
  assign stall_unused = ^stall_stat_i[STALL_W-1:1];

`ifdef ICACHE_EN
  inst_addr_t lookup_addr;

  assign lookup_addr = inst_valid_q ? next_pc(pc_q) : pc_q;

  inst_fetch_icache #(
    .LINES(ICACHE_LINES)
  ) u_icache (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .lookup_addr_i(lookup_addr),
    .hit_o        (cache_hit),
    .data_o       (cache_data),
    .fill_we_i    (fill_we),
    .fill_addr_i  (mem_addr_q),
    .fill_data_i  (mem_inst_i)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = ZERO_WORD;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_addr_d   = mem_addr_q;
    inst_buf_d   = inst_buf_q;
    inst_valid_d = inst_valid_q;
    mem_req_d    = mem_req_q;
    fill_we      = 1'b0;
    if (rdy_i) begin
      unique case (state_q)
        IF_IDLE: begin
          if (redirect) begin
            pc_d         = ex_branch_pc_i;
            inst_valid_d = 1'b0;
          end else if (consume) begin
            pc_d         = next_pc(pc_q);
            inst_valid_d = cache_hit;
            if (cache_hit) inst_buf_d = cache_data;
          end else if (!inst_valid_q) begin
            if (cache_hit) begin
              inst_valid_d = 1'b1;
              inst_buf_d   = cache_data;
            end else begin
              state_d    = IF_BUSY;
              mem_req_d  = 1'b1;
              mem_addr_d = pc_q;
            end
          end
        end
        IF_BUSY: begin
          fill_we = mem_done_i;
          if (redirect) begin
            pc_d         = ex_branch_pc_i;
            inst_valid_d = 1'b0;
            // The outstanding request cannot be withdrawn, so wait it out in DROP.
            if (mem_done_i) begin
              state_d   = IF_IDLE;
              mem_req_d = 1'b0;
            end else begin
              state_d = IF_DROP;
            end
          end else if (mem_done_i) begin
            state_d      = IF_IDLE;
            inst_buf_d   = mem_inst_i;
            inst_valid_d = 1'b1;
            mem_req_d    = 1'b0;
          end
        end
        IF_DROP: begin
          fill_we = mem_done_i;
          if (redirect) pc_d = ex_branch_pc_i;
          if (mem_done_i) begin
            state_d   = IF_IDLE;
            mem_req_d = 1'b0;
          end
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IF_IDLE;
      pc_q         <= '0;
      mem_addr_q   <= '0;
      inst_buf_q   <= ZERO_WORD;
      inst_valid_q <= 1'b0;
      mem_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_addr_q   <= mem_addr_d;
      inst_buf_q   <= inst_buf_d;
      inst_valid_q <= inst_valid_d;
      mem_req_q    <= mem_req_d;
    end
  end

  assign if_mem_req_o   = mem_req_q;
  assign if_mem_addr_o  = mem_addr_q;
  assign if_pc_o        = pc_q;
  assign if_inst_o      = inst_buf_q;
  assign if_stall_req_o = !inst_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a queue scoreboard holds the (pc, inst) pairs the
// bench expects to be presented; the icache scenario runs only when ICACHE_EN is defined.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst, rdy, ex_is_branch, mem_done;
  stall_t     stall_stat;
  inst_addr_t ex_branch_pc, id_pc;
  inst_t      mem_inst;
  logic       if_mem_req, if_stall_req;
  inst_addr_t if_mem_addr, if_pc;
  inst_t      if_inst;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  inst_fetch #(
    .ICACHE_LINES(64)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rdy_i         (rdy),
    .stall_stat_i  (stall_stat),
    .ex_is_branch_i(ex_is_branch),
    .ex_branch_pc_i(ex_branch_pc),
    .id_pc_i       (id_pc),
    .mem_done_i    (mem_done),
    .mem_inst_i    (mem_inst),
    .if_mem_req_o  (if_mem_req),
    .if_mem_addr_o (if_mem_addr),
    .if_pc_o       (if_pc),
    .if_inst_o     (if_inst),
    .if_stall_req_o(if_stall_req)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReq(input string tag, input logic [31:0] addr);
    int n = 0;
    while (!if_mem_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, {31'b0, if_mem_req}, 32'd1);
    check({tag, "_addr"}, if_mem_addr, addr);
  endtask

  task automatic respond(input int delay, input logic [31:0] addr, input logic [31:0] data,
                         input bit accept);
    repeat (delay) tick();
    mem_done = 1'b1;
    mem_inst = data;
    if (accept) expQ.push_back('{pc: addr, inst: data});
    tick();
    mem_done = 1'b0;
  endtask

  task automatic checkPresented(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s scoreboard_empty observed=none expected=entry", tag);
    end else begin
      e = expQ.pop_front();
      check({tag, "_stall"}, {31'b0, if_stall_req}, 32'd0);
      check({tag, "_pc"}, if_pc, e.pc);
      check({tag, "_inst"}, if_inst, e.inst);
    end
  endtask

  task automatic consume();
    stall_stat = '0;
    tick();
    stall_stat = 6'b000001;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; stall_stat = 6'b000001;
    ex_is_branch = 1'b0; ex_branch_pc = '0; id_pc = '0;
    mem_done = 1'b0; mem_inst = '0;

    // Test 1: reset values, first miss, consume
    tick(); tick();
    check("rst_pc", if_pc, 32'h0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_req", {31'b0, if_mem_req}, 32'd0);
    check("rst_addr", if_mem_addr, 32'h0);
    check("rst_stall", {31'b0, if_stall_req}, 32'd1);
    rst = 1'b0;
    waitReq("t1", 32'h0);
    respond(3, 32'h0, 32'h0000_0013, 1'b1);
    checkPresented("t1");
    check("t1_req_drop", {31'b0, if_mem_req}, 32'd0);
    consume();
    check("t1_pc4", if_pc, 32'h4);
    check("t1_stall_after", {31'b0, if_stall_req}, 32'd1);

    // Test 2: redirect while BUSY on 0x8 drops the returning data
    waitReq("t2a", 32'h4);
    respond(1, 32'h4, 32'h1111_1111, 1'b1);
    checkPresented("t2a");
    consume();
    waitReq("t2b", 32'h8);
    ex_is_branch = 1'b1; ex_branch_pc = 32'h100; id_pc = 32'h4;
    tick();
    ex_is_branch = 1'b0;
    check("t2_pc_redir", if_pc, 32'h100);
    check("t2_req_held", {31'b0, if_mem_req}, 32'd1);
    check("t2_addr_held", if_mem_addr, 32'h8);
    respond(1, 32'h8, 32'hDEAD_BEEF, 1'b0);
    check("t2_dropped", {31'b0, if_stall_req}, 32'd1);
    check("t2_req_off", {31'b0, if_mem_req}, 32'd0);
    waitReq("t2c", 32'h100);
    respond(2, 32'h100, 32'h2222_2222, 1'b1);
    checkPresented("t2c");

    // Test 3: branch resolved to the PC already in if_id is not a redirect
    ex_is_branch = 1'b1; ex_branch_pc = 32'h200; id_pc = 32'h200;
    tick();
    ex_is_branch = 1'b0;
    check("t3_pc", if_pc, 32'h100);
    check("t3_inst", if_inst, 32'h2222_2222);
    check("t3_stall", {31'b0, if_stall_req}, 32'd0);
    check("t3_req", {31'b0, if_mem_req}, 32'd0);

    // Test 4: stall hold, then rdy=0 freeze during BUSY
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_pc", if_pc, 32'h100);
      check("t4_hold_inst", if_inst, 32'h2222_2222);
    end
    consume();
    check("t4_pc", if_pc, 32'h104);
    waitReq("t4", 32'h104);
    rdy = 1'b0;
    ex_is_branch = 1'b1; ex_branch_pc = 32'h300; id_pc = 32'h0;
    mem_done = 1'b1; mem_inst = 32'h0BAD_0BAD;
    tick(); tick();
    check("t4_frz_pc", if_pc, 32'h104);
    check("t4_frz_req", {31'b0, if_mem_req}, 32'd1);
    check("t4_frz_addr", if_mem_addr, 32'h104);
    check("t4_frz_stall", {31'b0, if_stall_req}, 32'd1);
    mem_done = 1'b0; ex_is_branch = 1'b0; rdy = 1'b1;
    respond(0, 32'h104, 32'h3333_3333, 1'b1);
    checkPresented("t4");

    // Test 6: reset mid-BUSY, late mem_done ignored in IDLE
    consume();
    waitReq("t6", 32'h108);
    rst = 1'b1;
    tick();
    check("t6_pc", if_pc, 32'h0);
    check("t6_inst", if_inst, 32'h0);
    check("t6_req", {31'b0, if_mem_req}, 32'd0);
    check("t6_addr", if_mem_addr, 32'h0);
    check("t6_stall", {31'b0, if_stall_req}, 32'd1);
    rst = 1'b0;
    mem_done = 1'b1; mem_inst = 32'h5555_5555;
    tick();
    mem_done = 1'b0;
    check("t6_late_stall", {31'b0, if_stall_req}, 32'd1);
    check("t6_refetch_req", {31'b0, if_mem_req}, 32'd1);
    check("t6_refetch_addr", if_mem_addr, 32'h0);
    respond(1, 32'h0, 32'h0000_0044, 1'b1);
    checkPresented("t6");

`ifdef ICACHE_EN
    // Test 5: loop 0x0..0xC twice; second pass served by the icache
    for (int i = 1; i < 4; i++) begin
      consume();
      check("t5_p1_pc", if_pc, 32'(4 * i));
      check("t5_p1_miss", {31'b0, if_stall_req}, 32'd1);
      waitReq("t5_p1", 32'(4 * i));
      respond(1, 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1);
      checkPresented("t5_p1");
    end
    ex_is_branch = 1'b1; ex_branch_pc = 32'h0; id_pc = 32'h8;
    tick();
    ex_is_branch = 1'b0;
    check("t5_redir_pc", if_pc, 32'h0);
    check("t5_redir_stall", {31'b0, if_stall_req}, 32'd1);
    expQ.push_back('{pc: 32'h0, inst: 32'h0000_0044});
    tick();
    checkPresented("t5_hit0");
    check("t5_hit0_req", {31'b0, if_mem_req}, 32'd0);
    stall_stat = '0;
    for (int i = 1; i < 4; i++) begin
      expQ.push_back('{pc: 32'(4 * i), inst: 32'hA000_0000 + 32'(i)});
      tick();
      checkPresented("t5_p2");
      check("t5_p2_req", {31'b0, if_mem_req}, 32'd0);
    end
    stall_stat = 6'b000001;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
